// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter that shares one single-cycle-latency memory
// between an instruction fetch port (read only) and a data port.
// Data requests win by default. A fetch that has watched STARVE_LIMIT
// consecutive data grants takes the next cycle. Each read return is steered
// back to the port that issued it, and each port holds its last return.
module mem_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        rom_en,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_stall,
  // data port
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        ram_stall,
  // shared memory
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [3:0]  mem_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Which port the read issued last cycle belongs to.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INST = 2'd1,
    SRC_DATA = 2'd2
  } rd_src_t;

  rd_src_t          rd_src, rd_src_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic [31:0]      rom_hold, ram_hold;
  logic             starved;
  logic             grant_inst, grant_data;

  // State register: return source, starvation counter and per-port hold registers.
  always_ff @(posedge clk) begin
    // NOTE: hold registers are plain flops, not a memory, so they are reset
    // alongside the control state; a return in flight at reset is dropped.
    if (rst) begin
      rd_src     <= SRC_NONE;
      starve_cnt <= '0;
      rom_hold   <= '0;
      ram_hold   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rd_src     <= rd_src_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (rd_src == SRC_INST) rom_hold <= mem_rdata;
      if (rd_src == SRC_DATA) ram_hold <= mem_rdata;
    end
  end

  // Arbitration and next-state: data wins unless the fetch is starved.
  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    starved        = (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_inst     = !rst && rom_en && (!ram_cen || starved);
    grant_data     = !rst && ram_cen && !grant_inst;
    rd_src_nxt     = SRC_NONE;
    starve_cnt_nxt = starve_cnt;

    if (grant_inst)
      rd_src_nxt = SRC_INST;
    else if (grant_data && !ram_wen)
      rd_src_nxt = SRC_DATA;

    // Count data grants that a waiting fetch loses; saturate at the limit.
    if (!rom_en || grant_inst)
      starve_cnt_nxt = '0;
    else if (grant_data && !starved)
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
  end

  // Outputs: memory mux, stalls, and read-data steering.
  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_flag  = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;

    if (grant_inst) begin
      mem_cen  = 1'b1;
      mem_addr = rom_addr;
    end else if (grant_data) begin
      mem_cen   = 1'b1;
      mem_wen   = ram_wen;
      mem_flag  = ram_flag;
      mem_addr  = ram_addr;
      mem_wdata = ram_wdata;
    end

    rom_stall = !rst && rom_en  && !grant_inst;
    ram_stall = !rst && ram_cen && !grant_data;

    // A return cycle shows mem_rdata live; otherwise the held word.
    rom_data  = '0;
    ram_rdata = '0;
    if (!rst) begin
      rom_data  = (rd_src == SRC_INST) ? mem_rdata : rom_hold;
      ram_rdata = (rd_src == SRC_DATA) ? mem_rdata : ram_hold;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: hand-computed vector tables for the directed scenarios,
// a starvation sequence, and a randomized run against a behavioural model.
module tb_mem_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_stall;
  logic        ram_cen;
  logic        ram_wen;
  logic [3:0]  ram_flag;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_stall;
  logic        mem_cen;
  logic        mem_wen;
  logic [3:0]  mem_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_stall (rom_stall),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_flag  (ram_flag),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_stall (ram_stall),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_flag  (mem_flag),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rom_en;
    logic [31:0] rom_addr;
    logic        ram_cen, ram_wen;
    logic [3:0]  flag;
    logic [31:0] ram_addr, wdata, rdata;
    logic        e_cen, e_wen;
    logic [3:0]  e_flag;
    logic [31:0] e_addr, e_wdata;
    logic        e_rom_stall, e_ram_stall;
    logic [31:0] e_rom_data, e_ram_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic re, input logic [31:0] ra,
                       input logic dc, input logic dw, input logic [3:0] fl,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [31:0] rd);
    rst = r; rom_en = re; rom_addr = ra; ram_cen = dc; ram_wen = dw;
    ram_flag = fl; ram_addr = da; ram_wdata = wd; mem_rdata = rd;
  endtask

  // Apply one vector, compare at the falling edge, then advance one clock.
  task automatic apply_vec(input vec_t v, input string tag);
    drive(v.rst, v.rom_en, v.rom_addr, v.ram_cen, v.ram_wen, v.flag,
          v.ram_addr, v.wdata, v.rdata);
    @(negedge clk);
    check({tag, " mem_cen"},   32'(mem_cen),   32'(v.e_cen));
    check({tag, " mem_wen"},   32'(mem_wen),   32'(v.e_wen));
    check({tag, " mem_flag"},  32'(mem_flag),  32'(v.e_flag));
    check({tag, " mem_addr"},  mem_addr,       v.e_addr);
    check({tag, " mem_wdata"}, mem_wdata,      v.e_wdata);
    check({tag, " rom_stall"}, 32'(rom_stall), 32'(v.e_rom_stall));
    check({tag, " ram_stall"}, 32'(ram_stall), 32'(v.e_ram_stall));
    check({tag, " rom_data"},  rom_data,       v.e_rom_data);
    check({tag, " ram_rdata"}, ram_rdata,      v.e_ram_rdata);
    @(posedge clk);
    #1;
  endtask

  vec_t dir_tbl[13];
  vec_t alt_tbl[4];

  // Behavioural model state: consecutive lost fetch cycles, pending return owner
  // (0 none, 1 fetch, 2 data), and the last word each port received.
  int          m_lost;
  int          m_owner;
  logic [31:0] m_rom, m_ram;

  initial begin
    // rst rom_en rom_addr ram_cen ram_wen flag ram_addr wdata rdata |
    //   cen wen flag addr wdata rom_stall ram_stall rom_data ram_rdata
    dir_tbl[0]  = '{1,1,32'h10,1,0,4'h0,32'h4000_0000,32'h0,32'h9999_9999,
                    0,0,4'h0,32'h0,32'h0,0,0,32'h0,32'h0};
    dir_tbl[1]  = '{0,1,32'h10,0,0,4'h0,32'h0,32'h0,32'h9999_9999,
                    1,0,4'h0,32'h10,32'h0,0,0,32'h0,32'h0};
    dir_tbl[2]  = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'hE3A0_0001,
                    0,0,4'h0,32'h0,32'h0,0,0,32'hE3A0_0001,32'h0};
    dir_tbl[3]  = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'hDEAD_BEEF,
                    0,0,4'h0,32'h0,32'h0,0,0,32'hE3A0_0001,32'h0};
    dir_tbl[4]  = '{0,0,32'h0,1,1,4'b0011,32'h4000_0004,32'hAABB_CCDD,32'h1111_1111,
                    1,1,4'b0011,32'h4000_0004,32'hAABB_CCDD,0,0,32'hE3A0_0001,32'h0};
    dir_tbl[5]  = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'h2222_2222,
                    0,0,4'h0,32'h0,32'h0,0,0,32'hE3A0_0001,32'h0};
    dir_tbl[6]  = '{0,1,32'h20,1,0,4'h0,32'h4000_0008,32'h0,32'h3333_3333,
                    1,0,4'h0,32'h4000_0008,32'h0,1,0,32'hE3A0_0001,32'h0};
    dir_tbl[7]  = '{0,1,32'h20,0,0,4'h0,32'h0,32'h0,32'h5555_AAAA,
                    1,0,4'h0,32'h20,32'h0,0,0,32'hE3A0_0001,32'h5555_AAAA};
    dir_tbl[8]  = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'h0BAD_F00D,
                    0,0,4'h0,32'h0,32'h0,0,0,32'h0BAD_F00D,32'h5555_AAAA};
    dir_tbl[9]  = '{0,0,32'h0,1,0,4'h0,32'h4000_0000,32'h0,32'h4444_4444,
                    1,0,4'h0,32'h4000_0000,32'h0,0,0,32'h0BAD_F00D,32'h5555_AAAA};
    dir_tbl[10] = '{1,0,32'h0,0,0,4'h0,32'h0,32'h0,32'h1234_5678,
                    0,0,4'h0,32'h0,32'h0,0,0,32'h0,32'h0};
    dir_tbl[11] = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'h7777_7777,
                    0,0,4'h0,32'h0,32'h0,0,0,32'h0,32'h0};
    dir_tbl[12] = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'h6666_6666,
                    0,0,4'h0,32'h0,32'h0,0,0,32'h0,32'h0};

    // Alternating fetch/data reads after the starvation run.
    alt_tbl[0]  = '{0,1,32'h100,0,0,4'h0,32'h0,32'h0,32'hA0A0_A0A0,
                    1,0,4'h0,32'h100,32'h0,0,0,32'hC0DE_0005,32'hA0A0_A0A0};
    alt_tbl[1]  = '{0,0,32'h0,1,0,4'h0,32'h4000_0100,32'h0,32'hB1B1_B1B1,
                    1,0,4'h0,32'h4000_0100,32'h0,0,0,32'hB1B1_B1B1,32'hA0A0_A0A0};
    alt_tbl[2]  = '{0,1,32'h104,0,0,4'h0,32'h0,32'h0,32'hC2C2_C2C2,
                    1,0,4'h0,32'h104,32'h0,0,0,32'hB1B1_B1B1,32'hC2C2_C2C2};
    alt_tbl[3]  = '{0,0,32'h0,0,0,4'h0,32'h0,32'h0,32'hD3D3_D3D3,
                    0,0,4'h0,32'h0,32'h0,0,0,32'hD3D3_D3D3,32'hC2C2_C2C2};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) apply_vec(dir_tbl[i], $sformatf("dir%0d", i));

    // Six back-to-back data reads against a waiting fetch: four data grants,
    // the fifth cycle goes to the fetch, the sixth back to data.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 32'h30, 1, 0, 4'h0, 32'h4000_0010, 32'h0, 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
      check($sformatf("starve%0d mem_addr", i), mem_addr,
            (i == 4) ? 32'h30 : 32'h4000_0010);
      check($sformatf("starve%0d rom_stall", i), 32'(rom_stall), (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("starve%0d ram_stall", i), 32'(ram_stall), (i == 4) ? 32'd1 : 32'd0);
      if (i == 5) begin
        check("starve5 rom_data", rom_data, 32'hC0DE_0005);
        check("starve5 ram_rdata", ram_rdata, 32'hC0DE_0004);
      end
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 4; i++) apply_vec(alt_tbl[i], $sformatf("alt%0d", i));

    // Randomized run against the model; starts from reset so both agree.
    m_lost = 0; m_owner = 0; m_rom = '0; m_ram = '0;
    for (int n = 0; n < 400; n++) begin
      logic        r, re, dc, dw, fetch_wins, data_wins;
      logic [31:0] rd;
      string       tag;
      r  = (n == 0) || ($urandom_range(0, 39) == 0);
      re = ($urandom_range(0, 3) != 0);
      dc = ($urandom_range(0, 3) != 0);
      dw = $urandom_range(0, 1) == 1;
      rd = $urandom;
      drive(r, re, $urandom, dc, dw, 4'($urandom), $urandom, $urandom, rd);
      tag = $sformatf("rnd%0d", n);

      // A fetch gets the memory if data is idle or it has lost LIMIT cycles.
      fetch_wins = !r && re && (!dc || m_lost >= LIMIT);
      data_wins  = !r && dc && !fetch_wins;

      @(negedge clk);
      check({tag, " mem_cen"},   32'(mem_cen), 32'(fetch_wins || data_wins));
      check({tag, " mem_wen"},   32'(mem_wen), 32'(data_wins && dw));
      check({tag, " mem_flag"},  32'(mem_flag), data_wins ? 32'(ram_flag) : 32'd0);
      check({tag, " mem_addr"},  mem_addr,
            fetch_wins ? rom_addr : (data_wins ? ram_addr : 32'h0));
      check({tag, " mem_wdata"}, mem_wdata, data_wins ? ram_wdata : 32'h0);
      check({tag, " rom_stall"}, 32'(rom_stall), 32'(!r && re && !fetch_wins));
      check({tag, " ram_stall"}, 32'(ram_stall), 32'(!r && dc && !data_wins));
      check({tag, " rom_data"},  rom_data,  r ? 32'h0 : ((m_owner == 1) ? rd : m_rom));
      check({tag, " ram_rdata"}, ram_rdata, r ? 32'h0 : ((m_owner == 2) ? rd : m_ram));
      @(posedge clk);
      #1;

      if (r) begin
        m_lost = 0; m_owner = 0; m_rom = '0; m_ram = '0;
      end else begin
        if (m_owner == 1) m_rom = rd;
        if (m_owner == 2) m_ram = rd;
        m_owner = fetch_wins ? 1 : ((data_wins && !dw) ? 2 : 0);
        if (!re || fetch_wins) m_lost = 0;
        else if (data_wins)    m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
